// File: rtl/muldiv_seq.sv
// Multicycle signed multiply/divide sequencer, one bit per cycle, results in HI/LO.
// Define MULDIV_UNSIGNED_EN to add MULTU (op 10) and DIVU (op 11).
// States: IDLE wait start | ITER one bit per cycle | FIX sign fix, write HI/LO | ZERO divide-by-zero
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_ZERO = 2'd3;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;

    logic               use_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_sub;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

`ifdef MULDIV_UNSIGNED_EN
    assign use_signed = ~op[1];
`else
    logic op_unused;
    assign op_unused  = op[1];
    assign use_signed = 1'b1;
`endif

    assign a_neg = use_signed & a[WIDTH-1];
    assign b_neg = use_signed & b[WIDTH-1];
    assign abs_a = a_neg ? -a : a;
    assign abs_b = b_neg ? -b : b;

    // Multiply: add multiplicand into the upper half, then shift the whole product right.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mag_b[0] ? {1'b0, mag_a} : '0);

    // Divide: remainder lives in acc upper half, quotient bits shift into the lower half,
    // dividend bits are consumed MSB-first from mag_a.
    assign rem_shift = {acc[2*WIDTH-1:WIDTH], mag_a[WIDTH-1]};
    assign rem_ge    = rem_shift >= {1'b0, mag_b};
    assign rem_sub   = rem_shift[WIDTH-1:0] - mag_b;

    assign prod_fix = neg_q ? -acc : acc;
    assign q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state    <= S_IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            mag_a    <= '0;
            mag_b    <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_div <= op[0];
                        mag_a  <= abs_a;
                        mag_b  <= abs_b;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= (op[0] && (b == '0)) ? S_ZERO : S_ITER;
                    end
                end
                S_ITER: begin
                    cnt <= cnt + CW'(1);
                    if (is_div) begin
                        mag_a <= mag_a << 1;
                        if (rem_ge)
                            acc <= {rem_sub, acc[WIDTH-2:0], 1'b1};
                        else
                            acc <= {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                    end else begin
                        mag_b <= mag_b >> 1;
                        acc   <= {mul_sum, acc[WIDTH-1:1]};
                    end
                    if (cnt == CW'(WIDTH - 1))
                        state <= S_FIX;
                end
                S_FIX: begin
                    if (is_div) begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ZERO: begin
                    done     <= 1'b1;
                    div_zero <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed + random bench for muldiv_seq (WIDTH=32): model-driven scoreboard, immediate assertions.
module tb_muldiv_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_in;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset_in(reset_in), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    int           n_assert = 0;
    int           n_fail = 0;
    logic [W-1:0] ref_hi = '0;
    logic [W-1:0] ref_lo = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [W-1:0] ph, input logic [W-1:0] pl);
        exp_t        e;
        logic        uns;
        longint      sx, sy;
        logic [63:0] ux, uy, p, q, r;
`ifdef MULDIV_UNSIGNED_EN
        uns = o[1];
`else
        uns = 1'b0;
`endif
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        e.dz = 1'b0;
        if (!o[0]) begin
            if (uns) p = ux * uy;
            else     p = sx * sy;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (y == '0) begin
            e.dz = 1'b1;
            e.hi = ph;
            e.lo = pl;
        end else begin
            if (uns) begin
                q = ux / uy;
                r = ux % uy;
            end else begin
                q = sx / sy;
                r = sx % sy;
            end
            e.hi = r[31:0];
            e.lo = q[31:0];
        end
        return e;
    endfunction

    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        exp_t e;
        e = model(o, x, y, ref_hi, ref_lo);
        sb.push_back(e);
        ref_hi = e.hi;
        ref_lo = e.lo;
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 2'($urandom_range(0, 3));
        check({tag, "_busy_on"}, 64'(busy), 64'd1);
        check({tag, "_done_low"}, 64'(done), 64'd0);
        check({tag, "_dz_low"}, 64'(div_zero), 64'd0);
    endtask

    task automatic finish_op(input string tag, input int exp_lat, input int inject_at);
        int   cyc = 0;
        int   busy_cyc = 1;
        exp_t e;
        do begin
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
            if (!done && busy) busy_cyc++;
            if (cyc == inject_at && !done) begin
                start = 1'b1;
                op = 2'b01;
                a = 32'd100;
                b = 32'd0;
            end
        end while (!done && cyc < 200);
        check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_lat));
        check({tag, "_busy_off"}, 64'(busy), 64'd0);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_hi"}, 64'(hi), 64'(e.hi));
            check({tag, "_lo"}, 64'(lo), 64'(e.lo));
            check({tag, "_div_zero"}, 64'(div_zero), 64'(e.dz));
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_done;
        logic [1:0]  ro;
        logic [W-1:0] rx, ry;

        reset_in = 1'b1;
        start = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_dz", 64'(div_zero), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset_in = 1'b0;
        @(posedge clk);
        #1;

        launch(2'b00, 32'd7, 32'hFFFF_FFFD, "mult_7_m3");
        finish_op("mult_7_m3", 33, 0);
        check("mult_7_m3_hi_const", 64'(hi), 64'hFFFF_FFFF);
        check("mult_7_m3_lo_const", 64'(lo), 64'hFFFF_FFEB);

        launch(2'b01, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        finish_op("div_m7_2", 33, 0);
        check("div_m7_2_lo_const", 64'(lo), 64'hFFFF_FFFD);
        check("div_m7_2_hi_const", 64'(hi), 64'hFFFF_FFFF);

        launch(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
        finish_op("div_min_m1", 33, 0);
        check("div_min_m1_lo_const", 64'(lo), 64'h8000_0000);
        check("div_min_m1_hi_const", 64'(hi), 64'h0);

        launch(2'b01, 32'h3412, 32'h100, "div_prep");
        finish_op("div_prep", 33, 0);
        launch(2'b01, 32'd5, 32'd0, "div_zero");
        finish_op("div_zero", 1, 0);
        check("div_zero_hi_kept", 64'(hi), 64'h12);
        check("div_zero_lo_kept", 64'(lo), 64'h34);

        launch(2'b00, 32'd3, 32'd4, "mult_ignore");
        finish_op("mult_ignore", 33, 10);
        check("mult_ignore_lo_const", 64'(lo), 64'd12);
        check("mult_ignore_hi_const", 64'(hi), 64'd0);
        count_done(40, n_done);
        check("mult_ignore_extra_done", 64'(n_done), 64'd0);

        launch(2'b00, 32'hFFFF_FFFF, 32'd5, "mult_m1_5");
        finish_op("mult_m1_5", 33, 0);
        launch(2'b00, 32'h1234, 32'h5678, "mult_abort");
        repeat (14) @(posedge clk);
        #2;
        reset_in = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        sb.delete();
        ref_hi = '0;
        ref_lo = '0;
        @(negedge clk);
        reset_in = 1'b0;
        count_done(40, n_done);
        check("abort_no_done", 64'(n_done), 64'd0);
        launch(2'b00, 32'd2, 32'd2, "mult_2_2");
        finish_op("mult_2_2", 33, 0);
        check("mult_2_2_lo_const", 64'(lo), 64'd4);

        launch(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "op10_m1_m1");
        finish_op("op10_m1_m1", 33, 0);
        launch(2'b11, 32'hFFFF_FFF9, 32'd2, "op11_m7_2");
        finish_op("op11_m7_2", 33, 0);

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = (i == 5) ? 32'd0 : ((i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom);
            launch(ro, rx, ry, "rand");
            finish_op("rand", (ro[0] && ry == '0) ? 1 : 33, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Parametrised multicycle multiply/divide sequencer for the multicycle datapath. It runs signed (and optionally unsigned) WIDTH×WIDTH multiplication and WIDTH/WIDTH division one bit per cycle. Results land in the HI/LO register pair. The main control unit launches an operation with a `start`/`done` handshake, replacing its fixed-width `mult_control`/`mult_end`/`DivOp` strobes and adding divide-by-zero reporting.

## Interface
- `WIDTH`, default 32: operand width. Any value ≥ 4. HI and LO are each WIDTH bits.
- `clk` input 1: single clock, rising edge.
- `reset_in` input 1: asynchronous, active-high reset.
- `start` input 1: launch request. Sampled only in IDLE.
- `op` input 2: operation. 00 MULT (signed), 01 DIV (signed), 10 MULTU, 11 DIVU (10/11 only with macro; see Configuration).
- `a` input WIDTH: multiplicand or dividend. Sampled with `start`.
- `b` input WIDTH: multiplier or divisor. Sampled with `start`.
- `busy` output 1: an operation is in flight.
- `done` output 1: one-cycle pulse when results are valid or an exception is raised.
- `div_zero` output 1: one-cycle pulse coincident with `done` for a divide with `b`=0.
- `hi` output WIDTH: MULT upper half, or DIV remainder.
- `lo` output WIDTH: MULT lower half, or DIV quotient.

## Operation
- States:
  - IDLE → ITER on `start`, except DIV with `b`=0, which goes IDLE → ZERO.
  - ITER → FIX when the iteration counter reaches WIDTH-1.
  - FIX → IDLE.
  - ZERO → IDLE.
- IDLE, accepting `start`:
  - Latch `op`.
  - For signed ops, latch |a| and |b| as WIDTH-bit unsigned magnitudes, plus result sign flags:
    - MULT: sign(a) XOR sign(b).
    - DIV: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Clear the 2·WIDTH accumulator and the counter.
- ITER, one bit per cycle:
  - Multiply: shift-add over the multiplier LSB-first into the 2·WIDTH product.
  - Divide: restoring divide MSB-first, producing quotient and remainder magnitudes.
  - Counter is log2(WIDTH)+1 bits and increments each cycle.
- FIX:
  - Apply two's-complement negation per the sign flags.
  - Write `hi`/`lo`, pulse `done`.
- ZERO: pulse `done` and `div_zero`; `hi`/`lo` are left unchanged.
- Signed division truncates toward zero; remainder takes the dividend's sign.
- Signed MIN / -1 wraps: `lo`=MIN, `hi`=0. No exception is raised.
- `hi`/`lo` hold their value between operations and change only in FIX.
- `start` while `busy`: ignored. No queueing, no effect on the current operation.
- `op`, `a`, `b` may change freely after acceptance.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, counter=0.
- Reset mid-operation aborts immediately to IDLE with all reset values above. No partial write occurs.
- `start` accepted at edge k:
  - `busy`=1 after edge k.
  - ITER occupies edges k+1 … k+WIDTH.
  - FIX at edge k+WIDTH+1 updates `hi`/`lo`, raises `done`, drops `busy`.
  - Results are valid in the cycle after edge k+WIDTH+1 (latency WIDTH+1 cycles).
- Divide-by-zero: `done`=`div_zero`=1 after edge k+1, `busy`=0 after edge k+1. Latency is 1 cycle.
- `done` and `div_zero` are registered and last exactly one cycle.
- Back-to-back: `start` may be asserted during the `done` cycle; it is accepted at the next edge (state is IDLE).
- `busy` is registered; it is never asserted combinationally from `start`.

## Configuration
- `MULDIV_UNSIGNED_EN` defined:
  - `op` 10 = MULTU and 11 = DIVU: operands are used unsigned, and no sign fix is applied in FIX.
  - DIVU with `b`=0 raises `div_zero`.
- Undefined: `op[1]` is ignored. `op` 10 behaves as MULT and 11 as DIV. No unsigned logic is synthesised.

## Test plan
- WIDTH=32, MULT `a`=7, `b`=-3 (0xFFFFFFFD) → `done` 33 cycles after the accepting edge; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `busy` high for 33 cycles.
- DIV `a`=-7, `b`=2 → `lo`=0xFFFFFFFD (-3), `hi`=0xFFFFFFFF (-1). DIV `a`=0x80000000, `b`=0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `div_zero`=0.
- DIV `a`=5, `b`=0 after a prior MULT left `hi`=0x12, `lo`=0x34 → `done`=`div_zero`=1 one cycle after acceptance; `hi`/`lo` still 0x12/0x34.
- MULT 3×4 in flight; pulse `start` with DIV at cycle 10 → ignored; `lo`=12, `hi`=0; only one `done` pulse.
- MULT in flight; assert `reset_in` asynchronously at cycle 15 → `busy`, `hi`, `lo` = 0 immediately, no `done`. A new MULT 2×2 afterwards gives `lo`=4.
- With `MULDIV_UNSIGNED_EN`, WIDTH=8: MULTU 0xFF×0xFF → `hi`=0xFE, `lo`=0x01; DIVU 0xFF/0x10 → `lo`=0x0F, `hi`=0x0F. Without the macro, `op`=10 on 0xFF×0xFF → `hi`=0x00, `lo`=0x01.
